// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester valid/ready sequencer in front of a single-port synchronous SRAM.
// Round-robin grant by default; define SRAM_ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module sram_arbiter #(
    parameter int ADR  = 8,
    parameter int Data = 8
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            ReqValid0,
    input  logic            ReqWE0,
    input  logic [ADR-1:0]  ReqAddr0,
    input  logic [Data-1:0] ReqData0,
    output logic            ReqReady0,
    input  logic            ReqValid1,
    input  logic            ReqWE1,
    input  logic [ADR-1:0]  ReqAddr1,
    input  logic [Data-1:0] ReqData1,
    output logic            ReqReady1,
    output logic            RspValid0,
    output logic [Data-1:0] RspData0,
    output logic            RspValid1,
    output logic [Data-1:0] RspData1,
    output logic            MemCS,
    output logic            MemWE,
    output logic            MemRD,
    output logic [ADR-1:0]  MemAddr,
    output logic [Data-1:0] MemDataIn,
    input  logic [Data-1:0] MemDataOut,
    output logic            Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    logic            grant_id;
    logic            cmd_we;
    logic [Data-1:0] rsp_data0_q;
    logic [Data-1:0] rsp_data1_q;
    logic            sel_we;
    logic [ADR-1:0]  sel_addr;
    logic [Data-1:0] sel_data;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic            prio;
`endif

    always_comb begin
        ReqReady0 = 1'b0;
        ReqReady1 = 1'b0;
        if (state == IDLE) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            ReqReady0 = ReqValid0;
            ReqReady1 = ReqValid1 & ~ReqValid0;
`else
            ReqReady0 = ReqValid0 & (~ReqValid1 | ~prio);
            ReqReady1 = ReqValid1 & (~ReqValid0 | prio);
`endif
        end
    end

    always_comb begin
        sel_we   = ReqReady1 ? ReqWE1   : ReqWE0;
        sel_addr = ReqReady1 ? ReqAddr1 : ReqAddr0;
        sel_data = ReqReady1 ? ReqData1 : ReqData0;
    end

    // SRAM read data is only valid after the ACCESS edge, so the grantee sees it
    // straight through during RESP; the register keeps it once RESP ends.
    always_comb begin
        RspData0 = rsp_data0_q;
        RspData1 = rsp_data1_q;
        if (state == RESP) begin
            if (grant_id) RspData1 = MemDataOut;
            else          RspData0 = MemDataOut;
        end
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            grant_id    <= 1'b0;
            cmd_we      <= 1'b0;
            MemCS       <= 1'b0;
            MemWE       <= 1'b0;
            MemRD       <= 1'b0;
            MemAddr     <= '0;
            MemDataIn   <= '0;
            RspValid0   <= 1'b0;
            RspValid1   <= 1'b0;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            prio        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ReqReady0 | ReqReady1) begin
                        grant_id  <= ReqReady1;
                        cmd_we    <= sel_we;
                        MemAddr   <= sel_addr;
                        MemDataIn <= sel_data;
                        MemCS     <= 1'b1;
                        MemWE     <= sel_we;
                        MemRD     <= ~sel_we;
                        state     <= ACCESS;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                        prio      <= ReqReady0;
`endif
                    end
                end
                ACCESS: begin
                    MemCS <= 1'b0;
                    MemWE <= 1'b0;
                    MemRD <= 1'b0;
                    if (cmd_we) begin
                        state <= IDLE;
                    end else begin
                        state <= RESP;
                        if (grant_id) RspValid1 <= 1'b1;
                        else          RspValid0 <= 1'b1;
                    end
                end
                RESP: begin
                    RspValid0 <= 1'b0;
                    RspValid1 <= 1'b0;
                    if (grant_id) rsp_data1_q <= MemDataOut;
                    else          rsp_data0_q <= MemDataOut;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
